// File: rtl/idle_anim_sched_pkg.sv
// Shared types and constants for the idle animation scheduler.
// Used by the scheduler top, its tick divider and the LED bank interface.
package anim_pkg;

    typedef enum logic [1:0] {
        ANIM_FILL,
        ANIM_SPIN,
        ANIM_USER
    } anim_state_t;

    localparam int unsigned LAP_W       = 4;

    localparam int unsigned DEF_REGLEN  = 16;
    localparam int unsigned DEF_SNKLEN  = 8;
    localparam int unsigned DEF_DIV     = 4;
    localparam int unsigned DEF_TIMEOUT = 32;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/idle_anim_sched_if.sv
// LED bank interface between the user display source and the animation scheduler.
// The scheduler sits on the slave side; the user/top-level I/O is the master.
interface idle_anim_sched_if
    import anim_pkg::*;
#(
    parameter int unsigned REGLEN = DEF_REGLEN
) ();

    logic              user_req;
    logic [REGLEN-1:0] user_pat;
    logic [REGLEN-1:0] pattern;
    logic              owner;
    logic              tick;
    logic [LAP_W-1:0]  lap;

    modport master (
        output user_req,
        output user_pat,
        input  pattern,
        input  owner,
        input  tick,
        input  lap
    );

    modport slave (
        input  user_req,
        input  user_pat,
        output pattern,
        output owner,
        output tick,
        output lap
    );

endinterface

// File: rtl/idle_anim_sched_tick_gen.sv
// Free-running animation tick divider: one-cycle strobe every DIV hz100 cycles.
// With DIV=1 the strobe is constantly high.
module tick_gen
    import anim_pkg::*;
#(
    parameter int unsigned DIV = DEF_DIV
) (
    input  logic hz100,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = cnt_w(DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/idle_anim_sched.sv
// LED bank controller: snake animation (fill, then rotate with lap count) arbitrated
// against a user source. `IDLE_TIMEOUT_EN selects tick-based idle timeout on release.
module idle_anim_sched
    import anim_pkg::*;
#(
    parameter int unsigned REGLEN  = DEF_REGLEN,
    parameter int unsigned SNKLEN  = DEF_SNKLEN,
    parameter int unsigned DIV     = DEF_DIV,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              hz100,
    input  logic              reset,
    idle_anim_sched_if.slave  bus
);

    localparam int unsigned POS_W  = cnt_w(REGLEN);
    localparam int unsigned FILL_W = $clog2(SNKLEN + 1);

    logic tick;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .hz100 (hz100),
        .reset (reset),
        .tick  (tick)
    );

    anim_state_t       state_q, state_d;
    logic [REGLEN-1:0] anim_q, anim_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [LAP_W-1:0]  lap_q, lap_d;
    logic              exit_user;
    logic              owner_c;

`ifdef IDLE_TIMEOUT_EN
    localparam int unsigned IDLE_W = cnt_w(TIMEOUT);
    logic [IDLE_W-1:0] idle_q, idle_d;
`endif

    // Next-state: arbitration takes priority over animation advance
    always_comb begin
        state_d   = state_q;
        anim_d    = anim_q;
        fill_d    = fill_q;
        pos_d     = pos_q;
        lap_d     = lap_q;
        exit_user = 1'b0;
`ifdef IDLE_TIMEOUT_EN
        idle_d    = idle_q;
`endif

        case (state_q)
            ANIM_FILL, ANIM_SPIN: begin
                if (bus.user_req) begin
                    state_d = ANIM_USER;
`ifdef IDLE_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end else if (tick) begin
                    if (state_q == ANIM_FILL) begin
                        anim_d = {anim_q[REGLEN-2:0], 1'b1};
                        fill_d = fill_q - FILL_W'(1);
                        if (fill_q == FILL_W'(1)) begin
                            state_d = ANIM_SPIN;
                            pos_d   = '0;
                        end
                    end else begin
                        anim_d = {anim_q[REGLEN-2:0], anim_q[REGLEN-1]};
                        if (pos_q == POS_W'(REGLEN - 1)) begin
                            pos_d = '0;
                            lap_d = lap_q + LAP_W'(1);
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                        end
                    end
                end
            end
            ANIM_USER: begin
`ifdef IDLE_TIMEOUT_EN
                if (bus.user_req) begin
                    idle_d = '0;
                end else if (tick) begin
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        exit_user = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
`else
                exit_user = !bus.user_req;
`endif
            end
            default: begin
                state_d = ANIM_FILL;
            end
        endcase

        // Reclaim restarts the snake from empty; lap survives
        if (exit_user) begin
            state_d = ANIM_FILL;
            anim_d  = '0;
            fill_d  = FILL_W'(SNKLEN);
            pos_d   = '0;
`ifdef IDLE_TIMEOUT_EN
            idle_d  = '0;
`endif
        end
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q <= ANIM_FILL;
            anim_q  <= '0;
            fill_q  <= FILL_W'(SNKLEN);
            pos_q   <= '0;
            lap_q   <= '0;
`ifdef IDLE_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            anim_q  <= anim_d;
            fill_q  <= fill_d;
            pos_q   <= pos_d;
            lap_q   <= lap_d;
`ifdef IDLE_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

    assign owner_c     = (state_q == ANIM_USER);
    assign bus.owner   = owner_c;
    assign bus.pattern = owner_c ? bus.user_pat : anim_q;
    assign bus.tick    = tick;
    assign bus.lap     = lap_q;

endmodule

// File: tb/tb_idle_anim_sched.sv
// Randomized scoreboard bench for idle_anim_sched against a tick-count reference model.
// Honours `IDLE_TIMEOUT_EN the same way as the design.
module tb_idle_anim_sched;
    import anim_pkg::*;

    localparam int unsigned REGLEN  = 16;
    localparam int unsigned SNKLEN  = 8;
    localparam int unsigned DIV     = 4;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned NCYC    = 12000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    idle_anim_sched_if #(.REGLEN(REGLEN)) bus ();

    idle_anim_sched #(
        .REGLEN  (REGLEN),
        .SNKLEN  (SNKLEN),
        .DIV     (DIV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .hz100 (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [REGLEN-1:0] pattern;
        logic              owner;
        logic              tick;
        logic [LAP_W-1:0]  lap;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: animation described by ticks advanced since the last restart
    int unsigned m_cyc;
    int unsigned m_steps;
    int unsigned m_lap_base;
    int unsigned m_idle;
    bit          m_user;

    function automatic logic [REGLEN-1:0] snake(input int unsigned steps);
        logic [REGLEN-1:0] b;
        int unsigned       s;
        if (steps < SNKLEN) return REGLEN'((64'd1 << steps) - 64'd1);
        b = REGLEN'((64'd1 << SNKLEN) - 64'd1);
        s = (steps - SNKLEN) % REGLEN;
        return (b << s) | (b >> (REGLEN - s));
    endfunction

    function automatic int unsigned lap_of(input int unsigned steps, input int unsigned base);
        if (steps < SNKLEN) return base % 16;
        return (base + (steps - SNKLEN) / REGLEN) % 16;
    endfunction

    task automatic leave_user();
        m_lap_base = lap_of(m_steps, m_lap_base);
        m_steps    = 0;
        m_user     = 0;
        m_idle     = 0;
    endtask

    task automatic model_step(input bit r, input bit req);
        bit tk;
        if (r) begin
            m_cyc = 0; m_steps = 0; m_lap_base = 0; m_idle = 0; m_user = 0;
        end else begin
            tk    = (m_cyc == DIV - 1);
            m_cyc = (m_cyc + 1) % DIV;
            if (!m_user) begin
                if (req) begin
                    m_user = 1;
                    m_idle = 0;
                end else if (tk) begin
                    m_steps++;
                end
            end else begin
`ifdef IDLE_TIMEOUT_EN
                if (req) begin
                    m_idle = 0;
                end else if (tk) begin
                    m_idle++;
                    if (m_idle == TIMEOUT) leave_user();
                end
`else
                if (!req) leave_user();
`endif
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs after every edge against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("pattern", 32'(bus.pattern), 32'(e.pattern));
                chk("owner",   32'(bus.owner),   32'(e.owner));
                chk("tick",    32'(bus.tick),    32'(e.tick));
                chk("lap",     32'(bus.lap),     32'(e.lap));
            end
        end
    end

    // Driver: random activity bursts with dropouts, rare mid-run resets
    initial begin
        exp_t        e;
        bit          r;
        bit          req;
        int unsigned burst;
        rst          = 1'b1;
        bus.user_req = 1'b0;
        bus.user_pat = '0;
        burst        = 0;
        for (int c = 0; c < NCYC; c++) begin
            if (c < 3) r = 1'b1;
            else       r = ($urandom_range(0, 2999) == 0);
            if (burst > 0) begin
                burst--;
                req = ($urandom_range(0, 4) != 0);
            end else begin
                req = 1'b0;
                if ($urandom_range(0, 299) == 0) burst = $urandom_range(1, 40);
            end
            rst          = r;
            bus.user_req = req;
            bus.user_pat = REGLEN'($urandom);
            model_step(r, req);
            e.owner   = m_user;
            e.pattern = m_user ? bus.user_pat : snake(m_steps);
            e.tick    = (m_cyc == DIV - 1);
            e.lap     = LAP_W'(lap_of(m_steps, m_lap_base));
            q.push_back(e);
            @(negedge clk);
        end
        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
